sistema_ram_dp: RTL

//  Parametrised true-dual-port on-chip RAM for the Nios system interconnect; replaces the single-port RAM.
//  Two Avalon-MM slaves (s1: CPU data, s2: DMA/peripheral) share one inferred array with byte-enabled writes.

---
 rtl/sistema_ram_dp_pkg.sv | 40 ++++
 rtl/sistema_ram_dp_if.sv | 24 ++
 rtl/sistema_ram_dp_rd_pipe.sv | 44 ++++
 rtl/sistema_ram_dp.sv | 107 ++++++++++
 4 files changed

// File: rtl/sistema_ram_dp_pkg.sv
// Shared constants and helpers for the dual-port system RAM.
package sistema_ram_pkg;

  localparam int MIN_READ_LATENCY = 32'd1;
  localparam int MAX_READ_LATENCY = 32'd3;
  localparam int MAX_DATA_W       = 32'd512;
  localparam int MAX_BE_W         = MAX_DATA_W / 32'd8;

  // Ceiling log2; used to size the word address from DEPTH.
  function automatic int clog2(input int value);
    int result;
    result = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 32'd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Byte-lane merge: lanes with be set take new_word, others keep old_word.
  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] result;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sistema_ram_dp_if.sv
// One Avalon-MM slave port of the dual-port RAM (address, control, data, read return).
interface sistema_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sistema_ram_dp_rd_pipe.sv
// Read-return pipeline: LATENCY stages of data+valid, advancing only on en.
// Data stages load only behind a valid, so the output word holds its last
// returned value while no read is being delivered.
module sistema_ram_rd_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] valid_r;
  logic [DATA_W-1:0]  data_r [LATENCY];

  // Shift valid/data one stage per enabled cycle; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_r[i] <= '0;
      end
    end else if (en) begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/sistema_ram_dp.sv
// True dual-port RAM with byte-enabled writes, pipelined read return and
// fixed collision rules: s1 wins overlapping byte writes, and a read sees the
// other port's same-cycle write already merged in.
module sistema_ram_dp
  import sistema_ram_pkg::*;
#(
  parameter string INIT_FILE    = "",
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 4096,
  parameter int    READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reset_req,
  input  logic            clken,
  sistema_ram_dp_if.slave s1,
  sistema_ram_dp_if.slave s2
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  if ((READ_LATENCY < MIN_READ_LATENCY) || (READ_LATENCY > MAX_READ_LATENCY) ||
      ((DATA_W % 8) != 0) || (DATA_W > MAX_DATA_W) || (DEPTH < 2)) begin : g_param_check
    $error("sistema_ram_dp: illegal READ_LATENCY, DATA_W or DEPTH");
  end

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              clocken_s;
  logic              in_range1_s, in_range2_s;
  logic              we1_s, we2_s;
  logic              re1_s, re2_s;
  logic [DATA_W-1:0] rd_data1_s, rd_data2_s;

  // Address range check: words at or beyond DEPTH are not backed by the array.
  assign in_range1_s = ({1'b0, s1.address} < (ADDR_W+1)'(DEPTH));
  assign in_range2_s = ({1'b0, s2.address} < (ADDR_W+1)'(DEPTH));

  assign clocken_s = clken & ~reset_req;
  // Write wins over read on the same port; out-of-range writes are dropped.
  assign we1_s = s1.chipselect & clocken_s & s1.write & in_range1_s;
  assign we2_s = s2.chipselect & clocken_s & s2.write & in_range2_s;
  assign re1_s = s1.chipselect & clocken_s & s1.read & ~s1.write;
  assign re2_s = s2.chipselect & clocken_s & s2.read & ~s2.write;

  // Byte-lane array update; s1 is applied last so it owns overlapping lanes.
  always @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (we2_s && s2.byteenable[b]) begin
        mem_r[s2.address][8*b +: 8] <= s2.writedata[8*b +: 8];
      end
      if (we1_s && s1.byteenable[b]) begin
        mem_r[s1.address][8*b +: 8] <= s1.writedata[8*b +: 8];
      end
    end
  end

  // s1 read word: zero when out of range, s2's same-cycle write forwarded in.
  always_comb begin
    rd_data1_s = '0;
    if (!in_range1_s) begin
      rd_data1_s = '0;
    end else if (we2_s && (s2.address == s1.address)) begin
      rd_data1_s = DATA_W'(merge_be(MAX_DATA_W'(mem_r[s1.address]),
                                    MAX_DATA_W'(s2.writedata),
                                    MAX_BE_W'(s2.byteenable)));
    end else begin
      rd_data1_s = mem_r[s1.address];
    end
  end

  // s2 read word: zero when out of range, s1's same-cycle write forwarded in.
  always_comb begin
    rd_data2_s = '0;
    if (!in_range2_s) begin
      rd_data2_s = '0;
    end else if (we1_s && (s1.address == s2.address)) begin
      rd_data2_s = DATA_W'(merge_be(MAX_DATA_W'(mem_r[s2.address]),
                                    MAX_DATA_W'(s1.writedata),
                                    MAX_BE_W'(s1.byteenable)));
    end else begin
      rd_data2_s = mem_r[s2.address];
    end
  end

  sistema_ram_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd_pipe1 (
    .clk       (clk),
    .reset     (reset),
    .en        (clocken_s),
    .in_valid  (re1_s),
    .in_data   (rd_data1_s),
    .out_valid (s1.readdatavalid),
    .out_data  (s1.readdata)
  );

  sistema_ram_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd_pipe2 (
    .clk       (clk),
    .reset     (reset),
    .en        (clocken_s),
    .in_valid  (re2_s),
    .in_data   (rd_data2_s),
    .out_valid (s2.readdatavalid),
    .out_data  (s2.readdata)
  );

endmodule
